// File: rtl/squeeze_serializer.sv
// squeeze_serializer: splits squeezed blocks into LSB-first packets until the requested length is emitted
module squeeze_serializer #(
    parameter int IN_WIDTH = 256,
    parameter int OUT_WIDTH = 8,
    parameter int LENGTH_WIDTH = 16,
    parameter int PACKETS_IN_INPUT = IN_WIDTH / OUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    start,
    input  logic [LENGTH_WIDTH-1:0] out_length,
    input  logic [IN_WIDTH-1:0]     in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_WIDTH-1:0]    serial_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    done
);
    localparam int CW = PACKETS_IN_INPUT > 1 ? $clog2(PACKETS_IN_INPUT) : 1;
    typedef enum logic [1:0] {IDLE, WAIT_BLOCK, SHIFT, DONE} state_t;
    state_t                  state;
    logic [IN_WIDTH-1:0]     sh;
    logic [CW-1:0]           pkt_cnt;
    logic [LENGTH_WIDTH-1:0] remaining;
    assign serial_out = sh[OUT_WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            sh        <= '0;
            pkt_cnt   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    remaining <= out_length;
                    if (out_length == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= WAIT_BLOCK;
                        in_ready <= 1'b1;
                    end
                end
                WAIT_BLOCK: if (in_valid) begin
                    sh        <= in;
                    pkt_cnt   <= '0;
                    state     <= SHIFT;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b1;
                end
                SHIFT: if (out_ready) begin
                    sh        <= sh >> OUT_WIDTH;
                    pkt_cnt   <= pkt_cnt + 1'b1;
                    remaining <= remaining - 1'b1;
                    // length exhaustion wins over block exhaustion; leftover bytes are dropped
                    if (remaining == LENGTH_WIDTH'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else if (pkt_cnt == CW'(PACKETS_IN_INPUT - 1)) begin
                        state     <= WAIT_BLOCK;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_squeeze_serializer.sv
// tb_squeeze_serializer: directed checks of packet order, length handling, backpressure and clear
module tb_squeeze_serializer;
    logic         clk = 0;
    logic         clear = 1;
    logic         start = 0;
    logic [15:0]  out_length = '0;
    logic [255:0] in = '0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [7:0]   serial_out;
    logic         out_valid;
    logic         out_ready = 0;
    logic         done;
    int           checks = 0;
    int           failures = 0;
    logic [255:0] blocks [2];
    logic [7:0]   got_q [$];
    int           hs;
    int           dones;

    squeeze_serializer dut (
        .clk(clk), .clear(clear), .start(start), .out_length(out_length),
        .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .serial_out(serial_out), .out_valid(out_valid), .out_ready(out_ready),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int len, input bit stall, input bit restart, input bit abort);
        int  stalls = 0;
        bit  pulsed = 0;
        bit  seen_ir = 0;
        bit  seen_ov = 0;
        int  done_c = -1;
        out_length = 16'(len);
        start = 1;
        step();
        start = 0;
        hs = 0;
        dones = 0;
        got_q.delete();
        in_valid = 1;
        out_ready = 1;
        for (int c = 0; c < 200; c++) begin
            seen_ir |= in_ready;
            seen_ov |= out_valid;
            if (done) begin
                dones++;
                done_c = c;
                break;
            end
            if (abort && got_q.size() == 10) begin
                clear = 1;
                in_valid = 0;
                step();
                clear = 0;
                chk("clr_out_valid", out_valid, 0);
                chk("clr_in_ready", in_ready, 0);
                chk("clr_done", done, 0);
                chk("clr_state", dut.state, 0);
                step();
                chk("clr_no_done", done, 0);
                chk("clr_idle_in_ready", in_ready, 0);
                return;
            end
            if (stall && got_q.size() == 10 && stalls < 5) begin
                out_ready = 0;
                chk("stall_data", serial_out, blocks[0][87:80]);
                chk("stall_valid", out_valid, 1);
                stalls++;
            end else
                out_ready = 1;
            start = restart && !pulsed && got_q.size() == 5;
            if (start) begin
                pulsed = 1;
                out_length = 16'd99;
            end
            in = blocks[hs > 0 ? 1 : 0];
            if (in_ready && in_valid) hs++;
            if (out_valid && out_ready) got_q.push_back(serial_out);
            step();
        end
        in_valid = 0;
        start = 0;
        chk("done_seen", dones, 1);
        chk("len", got_q.size(), len);
        chk("handshakes", hs, (len + 31) / 32);
        for (int i = 0; i < got_q.size() && i < len; i++)
            chk($sformatf("byte%0d", i), got_q[i], blocks[i / 32][(i % 32) * 8 +: 8]);
        if (len == 0) begin
            chk("len0_done_cycle", done_c, 0);
            chk("len0_in_ready", seen_ir, 0);
            chk("len0_out_valid", seen_ov, 0);
        end
        if (len == 32 && got_q.size() == 32) begin
            chk("first_byte", got_q[0], 8'h1f);
            chk("last_byte", got_q[31], 8'h80);
        end
        if (len == 40 && got_q.size() == 40) begin
            chk("b_byte0", got_q[32], 8'ha0);
            chk("b_byte7", got_q[39], 8'ha7);
        end
        step();
        chk("done_one_cycle", done, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            blocks[0][k*8 +: 8] = 8'(k * 5 + 'h1f);
            blocks[1][k*8 +: 8] = 8'(8'ha0 + k);
        end
        blocks[0][255:248] = 8'h80;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_serial_out", serial_out, 0);
        clear = 0;
        step();
        run(32, 0, 0, 0);
        run(40, 0, 0, 0);
        run(0, 0, 0, 0);
        run(32, 1, 0, 0);
        run(32, 0, 0, 1);
        run(4, 0, 0, 0);
        run(32, 0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/squeeze_serializer.md
SQUEEZE_SERIALIZER -- requirements
Module: squeeze_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 256, width of each squeezed block.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, width of each emitted byte packet.
REQ-003 SHALL have parameter LENGTH_WIDTH, default 16, width of the requested output length.
REQ-004 SHALL have parameter PACKETS_IN_INPUT, default IN_WIDTH/OUT_WIDTH, the packets per block.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-006 SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: a squeeze-request pulse.
REQ-008 SHALL have port out_length, input, LENGTH_WIDTH bits: total packets to emit, sampled with start.
REQ-009 SHALL have port in, input, IN_WIDTH bits: the squeezed block.
REQ-010 SHALL have port in_valid, input, 1 bit: in holds a valid block.
REQ-011 SHALL have port in_ready, output, 1 bit: the block is requested and accepted when in_valid is high.
REQ-012 SHALL have port serial_out, output, OUT_WIDTH bits: the current packet.
REQ-013 SHALL have port out_valid, output, 1 bit: serial_out is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts serial_out.
REQ-015 SHALL have port done, output, 1 bit: a one-cycle pulse when the request completes.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_BLOCK, SHIFT and DONE.
REQ-017 SHALL, in IDLE on start, latch out_length into remaining and go to WAIT_BLOCK; if out_length==0 it SHALL go to DONE instead.
REQ-018 SHALL ignore start in every state other than IDLE; out_length is not resampled while busy.
REQ-019 SHALL drive in_ready=1 only in WAIT_BLOCK; in_valid without in_ready SHALL have no effect.
REQ-020 SHALL, on the in_valid&&in_ready handshake, load the shift register with in, set pkt_cnt=0 and go to SHIFT.
REQ-021 SHALL drive out_valid=1 only in SHIFT, with serial_out = shift register [OUT_WIDTH-1:0]; the first packet is valid the cycle after the input handshake.
REQ-022 SHALL emit packets LSB-first, so packet k = in[8k+7:8k] (byte 0 first), matching the upstream deserializer ordering.
REQ-023 SHALL, on out_valid&&out_ready, logically shift the register right by OUT_WIDTH and increment pkt_cnt and decrement remaining (both wrap-free within their widths).
REQ-024 SHALL hold serial_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL use the following priority after a SHIFT transfer: remaining reaching 0 -> DONE (the rest of the block is discarded); otherwise pkt_cnt==PACKETS_IN_INPUT-1 -> WAIT_BLOCK; otherwise stay in SHIFT.
REQ-026 SHALL, in DONE, drive done=1 for exactly one cycle and then return to IDLE.
REQ-027 SHALL give a request for L packets exactly ceil(L/PACKETS_IN_INPUT) input handshakes and exactly L output transfers.
REQ-028 SHALL size pkt_cnt as $clog2(PACKETS_IN_INPUT) bits.

Reset
REQ-029 SHALL, while clear=1 at a clock edge, set state=IDLE, in_ready=0, out_valid=0, done=0, serial_out=0, shift register=0, pkt_cnt=0 and remaining=0.
REQ-030 SHALL give clear priority over start, in_valid and out_ready in the same cycle; a clear in mid-operation SHALL abandon the request with no done pulse.

Verification
REQ-031 SHALL cover: start with out_length=32, then one block with in[7:0]=0x1f and in[255:248]=0x80 -> 32 transfers, first 0x1f and last 0x80; one in_ready handshake; done pulses once.
REQ-032 SHALL cover: out_length=40 with blocks A and B -> 32 bytes of A, in_ready re-asserted, then B bytes 0..7, then done; B bytes 8..31 are never emitted.
REQ-033 SHALL cover: out_length=0 -> done=1 on the cycle after start, with in_ready and out_valid never asserted.
REQ-034 SHALL cover: out_ready held low for 5 cycles mid-block -> serial_out and out_valid unchanged over those cycles, with no packet lost or duplicated.
REQ-035 SHALL cover: clear asserted during SHIFT at packet 10 -> next cycle out_valid=0 and state IDLE; a following start with out_length=4 runs normally.
REQ-036 SHALL cover: start pulsed with out_length=99 during SHIFT of a 32-packet request -> ignored; exactly 32 packets and a single done.
